// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexed driver for a 4-digit, common-anode seven-segment display
// (Nexys2 style: active-low anodes and shared active-low cathodes).
//
// - A free-running divider splits time into digit slots of 2^DIV_W cycles.
//   The 2-bit digit pointer advances on every divider wrap.
// - The first BLANK_CYC cycles of each slot keep every anode off. This stops
//   the previous digit's pattern from ghosting onto the next digit.
// - value/dp_in are captured into shadow registers once per full scan, at
//   divider==0 with digit_ptr==0. A scan therefore never mixes two input
//   values.
// - an/seg/dp are registered and lag the divider/state/pointer by one cycle.
//
// Optional build macro:
//   SEVENSEG_LZ_SUPPRESS_EN - blank leading zero digits (digits 3..1) whose
//   shadow nibbles from that digit upwards are all zero and whose decimal
//   point is off. Digit 0 always shows. When the macro is undefined, no
//   suppression logic is built.

module sevenseg_scan_driver #(
  parameter int DIV_W     = 16,  // slot length is 2^DIV_W cycles
  parameter int BLANK_CYC = 64   // blank cycles at slot start, 1 .. 2^DIV_W-2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_ptr
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
  localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_MAX   = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // State registers
  logic [DIV_W-1:0] div_q;
  logic [1:0]       ptr_q;
  state_e           state_q;
  logic [15:0]      sh_val_q;
  logic [3:0]       sh_dp_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  // Next-state values
  logic [DIV_W-1:0] div_d;
  logic [1:0]       ptr_d;
  state_e           state_d;
  logic [15:0]      sh_val_d;
  logic [3:0]       sh_dp_d;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  // Combinational helpers
  logic             wrap_s;
  logic             scan_start_s;
  logic [3:0]       nib_s;
  logic             sdp_s;
  logic             supp_s;
  logic             lit_s;

  // Divider, digit pointer and blank/drive state sequencing.
  always_comb begin
    wrap_s = (div_q == DIV_MAX);
    if (wrap_s) begin
      div_d = DIV_ZERO;
      ptr_d = ptr_q + 2'd1;
    end else begin
      div_d = div_q + DIV_ONE;
      ptr_d = ptr_q;
    end
    // The state tracks the divider value it will be paired with, so
    // state_q is BLANK exactly while div_q < BLANK_CYC. A wrap always
    // starts a fresh blank window.
    if (wrap_s || (div_d < BLANK_LIM)) begin
      state_d = ST_BLANK;
    end else begin
      state_d = ST_DRIVE;
    end
  end

  // Shadow capture once per scan, at the very start of slot 0.
  always_comb begin
    scan_start_s = (div_q == DIV_ZERO) && (ptr_q == 2'd0);
    if (scan_start_s) begin
      sh_val_d = value;
      sh_dp_d  = dp_in;
    end else begin
      sh_val_d = sh_val_q;
      sh_dp_d  = sh_dp_q;
    end
  end

  // Select the shadow nibble and decimal point of the current digit.
  always_comb begin
    case (ptr_q)
      2'd0:    nib_s = sh_val_q[3:0];
      2'd1:    nib_s = sh_val_q[7:4];
      2'd2:    nib_s = sh_val_q[11:8];
      2'd3:    nib_s = sh_val_q[15:12];
      default: nib_s = 4'h0;
    endcase
    sdp_s = sh_dp_q[ptr_q];
  end

`ifdef SEVENSEG_LZ_SUPPRESS_EN
  // Leading-zero suppression: digit i blanks when nibbles i..3 are all zero
  // and its own decimal point is off. Digit 0 always shows.
  always_comb begin
    case (ptr_q)
      2'd3:    supp_s = (sh_val_q[15:12] == 4'h0) && !sh_dp_q[3];
      2'd2:    supp_s = (sh_val_q[15:8] == 8'h00) && !sh_dp_q[2];
      2'd1:    supp_s = (sh_val_q[15:4] == 12'h000) && !sh_dp_q[1];
      2'd0:    supp_s = 1'b0;
      default: supp_s = 1'b0;
    endcase
  end
`else
  // Every digit always shows its nibble, leading zeros included.
  assign supp_s = 1'b0;
`endif

  // Output decode: the current digit lights only in DRIVE with en high.
  always_comb begin
    lit_s = (state_q == ST_DRIVE) && en && !supp_s;
    if (lit_s) begin
      an_d  = ~(4'b0001 << ptr_q);
      seg_d = hex_to_seg(nib_s);
      dp_d  = ~sdp_s;
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // All sequential state, with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_ZERO;
      ptr_q    <= 2'd0;
      state_q  <= ST_BLANK;
      sh_val_q <= 16'h0000;
      sh_dp_q  <= 4'h0;
      an_q     <= 4'b1111;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_ptr = ptr_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver
// Self-checking bench for sevenseg_scan_driver with DIV_W=4, BLANK_CYC=2
// (16-cycle slots, 64-cycle scan). The reference model is written in terms
// of elapsed cycles since reset: slot = (t/16)%4 and position = t%16. It
// compares an/seg/dp/digit_ptr after every clock edge. Honours
// SEVENSEG_LZ_SUPPRESS_EN in the same way as the design.

module tb_sevenseg_scan_driver;

  localparam int SLOT = 16;
  localparam int BLNK = 2;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_ptr;

  int n_assert;
  int n_fail;

  // Reference model state
  int          m_t;       // clock edges since reset released
  logic [15:0] m_sh_val;
  logic [3:0]  m_sh_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  logic [6:0] hex_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scan_driver #(
    .DIV_W    (4),
    .BLANK_CYC(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dp_in    (dp_in),
    .en       (en),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .digit_ptr(digit_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic suppressed(input int p);
`ifdef SEVENSEG_LZ_SUPPRESS_EN
    return (p > 0) && ((m_sh_val >> (4 * p)) == 16'h0000) && !m_sh_dp[p];
`else
    return (p < 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // Advance one clock edge: update the model from the pre-edge inputs,
  // then sample the DUT 1 time unit after the edge and compare.
  task automatic tick();
    int   pos;
    int   slot;
    logic lit;
    if (rst) begin
      m_t      = 0;
      m_sh_val = 16'h0000;
      m_sh_dp  = 4'h0;
      m_an     = 4'b1111;
      m_seg    = 7'h7F;
      m_dp     = 1'b1;
    end else begin
      pos  = m_t % SLOT;
      slot = (m_t / SLOT) % 4;
      lit  = (pos >= BLNK) && en && !suppressed(slot);
      if (lit) begin
        m_an  = ~(4'b0001 << slot);
        m_seg = hex_tab[m_sh_val[4*slot +: 4]];
        m_dp  = ~m_sh_dp[slot];
      end else begin
        m_an  = 4'b1111;
        m_seg = 7'h7F;
        m_dp  = 1'b1;
      end
      if (m_t % (4 * SLOT) == 0) begin
        m_sh_val = value;
        m_sh_dp  = dp_in;
      end
      m_t = m_t + 1;
    end
    @(posedge clk);
    #1;
    chk("an", {12'h000, an}, {12'h000, m_an});
    chk("seg", {9'h000, seg}, {9'h000, m_seg});
    chk("dp", {15'h0000, dp}, {15'h0000, m_dp});
    chk("digit_ptr", {14'h0000, digit_ptr}, 16'((m_t / SLOT) % 4));
    chk("one_anode", 16'($countones(~an) <= 1), 16'h0001);
  endtask

  task automatic run_until_phase(input int ph);
    for (int k = 0; k < 4 * SLOT; k++) begin
      if (m_t % (4 * SLOT) == ph) break;
      tick();
    end
  endtask

  initial begin
    int n;
    n_assert = 0;
    n_fail   = 0;
    m_t      = 0;
    rst      = 1'b1;
    value    = 16'h1234;
    dp_in    = 4'h0;
    en       = 1'b1;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst_an", {12'h000, an}, 16'h000F);
    chk("rst_seg", {9'h000, seg}, 16'h007F);
    rst = 1'b0;

    // Blank window after release, first lit digit on the 3rd edge
    tick();
    tick();
    chk("blank_an", {12'h000, an}, 16'h000F);
    tick();
    chk("first_an", {12'h000, an}, 16'h000E);
    chk("first_seg", {9'h000, seg}, 16'h0019);

    // Static display 1234 for the rest of the scan
    run_until_phase(SLOT + 8);
    chk("d1_an", {12'h000, an}, 16'h000D);
    chk("d1_seg", {9'h000, seg}, 16'h0030);

    // Tear-free update while digit_ptr==1
    value = 16'hABCD;
    run_until_phase(2 * SLOT + 8);
    chk("tear_seg2", {9'h000, seg}, 16'h0024);
    run_until_phase(3 * SLOT + 8);
    chk("tear_seg3", {9'h000, seg}, 16'h0079);
    run_until_phase(8);
    chk("new_seg0", {9'h000, seg}, 16'h0021);
    run_until_phase(3 * SLOT + 8);
    chk("new_seg3", {9'h000, seg}, 16'h0008);

    // Decimal point on digit 2, enable drop and restore
    dp_in = 4'b0100;
    run_until_phase(2 * SLOT + 8);
    chk("dp2", {15'h0000, dp}, 16'h0000);
    run_until_phase(2 * SLOT + 10);
    en = 1'b0;
    tick();
    chk("en_off_an", {12'h000, an}, 16'h000F);
    repeat (12) tick();
    en = 1'b1;
    repeat (SLOT) tick();

    // Mid-operation reset during DRIVE of slot 2
    run_until_phase(2 * SLOT + 6);
    rst = 1'b1;
    tick();
    chk("mid_rst_ptr", {14'h0000, digit_ptr}, 16'h0000);
    rst   = 1'b0;
    value = 16'h00C0;
    dp_in = 4'b0000;
    repeat (4 * SLOT) tick();

    // Leading zeros
    value = 16'h0005;
    run_until_phase(1);
    repeat (4 * SLOT) tick();
    dp_in = 4'b0100;
    run_until_phase(1);
    repeat (4 * SLOT) tick();

    // Randomized stretches with occasional reset and enable changes
    for (int it = 0; it < 40; it++) begin
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 9) == 0);
      n   = $urandom_range(1, 48);
      tick();
      rst = 1'b0;
      repeat (n) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
